red_peak_detector: RTL and testbench

RED_PEAK_DETECTOR -- requirements
Module: red_peak_detector

---
 rtl/red_peak_detector.sv | 147 ++++++++++++++
 tb/tb_red_peak_detector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/red_peak_detector.sv
// rtl/red_peak_detector.sv - hysteresis peak/trough tracker producing beat period and AC amplitude
//
// Ports:
//   CLK_Filter      in   1   single clock, rising edge
//   rst             in   1   synchronous active-high reset
//   Sample_Valid    in   1   one-cycle strobe for a new filtered sample
//   In_RED_Filtered in  20   unsigned filtered red sample
//   Peak_Value      out 20   last accepted peak
//   Trough_Value    out 20   last confirmed trough
//   AC_Amplitude    out 20   peak minus trough at the last accepted beat
//   Beat_Period     out 16   samples between the last two accepted peaks
//   Beat_Valid      out  1   one-cycle pulse per accepted beat
//   Timeout         out  1   no beat accepted within MAX_PERIOD samples
module red_peak_detector #(
  parameter logic [19:0] HYST       = 20'd512,
  parameter logic [15:0] MIN_PERIOD = 16'd100,
  parameter logic [15:0] MAX_PERIOD = 16'd1000
) (
  input  logic        CLK_Filter,
  input  logic        rst,
  input  logic        Sample_Valid,
  input  logic [19:0] In_RED_Filtered,
  output logic [19:0] Peak_Value,
  output logic [19:0] Trough_Value,
  output logic [19:0] AC_Amplitude,
  output logic [15:0] Beat_Period,
  output logic        Beat_Valid,
  output logic        Timeout
);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [19:0] r_run_max;
  logic [19:0] r_run_min;
  logic        r_have_peak;
  logic [19:0] r_peak;
  logic [19:0] r_trough;
  logic [19:0] r_ac;
  logic [15:0] r_period;
  logic        r_beat_valid;
  logic        r_timeout;

  logic [19:0] w_max_next;
  logic [19:0] w_min_next;
  logic [20:0] w_fall_amt;
  logic [20:0] w_rise_amt;
  logic        w_peak_conf;
  logic        w_trough_conf;
  logic [15:0] w_cnt_next;
  logic        w_accept;
  logic [20:0] w_ac_diff;

  assign w_max_next = (In_RED_Filtered > r_run_max) ? In_RED_Filtered : r_run_max;
  assign w_min_next = (In_RED_Filtered < r_run_min) ? In_RED_Filtered : r_run_min;

  // Widened by one bit so the full 0..20'hFFFFF input range never wraps.
  assign w_fall_amt = {1'b0, w_max_next} - {1'b0, In_RED_Filtered};
  assign w_rise_amt = {1'b0, In_RED_Filtered} - {1'b0, w_min_next};

  assign w_peak_conf   = (r_state == ST_RISING)  && (w_fall_amt >= {1'b0, HYST});
  assign w_trough_conf = (r_state == ST_FALLING) && (w_rise_amt >= {1'b0, HYST});

  // Count including the current sample, saturating at the timeout limit.
  assign w_cnt_next = (r_cnt >= MAX_PERIOD) ? MAX_PERIOD : r_cnt + 16'd1;

  assign w_accept = w_peak_conf && r_have_peak &&
                    (w_cnt_next >= MIN_PERIOD) && (w_cnt_next < MAX_PERIOD);

  // Bit 20 set means the trough lies above the peak; amplitude clamps to 0.
  assign w_ac_diff = {1'b0, w_max_next} - {1'b0, r_trough};

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_cnt        <= 16'd0;
      r_run_max    <= 20'd0;
      r_run_min    <= 20'd0;
      r_have_peak  <= 1'b0;
      r_peak       <= 20'd0;
      r_trough     <= 20'd0;
      r_ac         <= 20'd0;
      r_period     <= 16'd0;
      r_beat_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_beat_valid <= 1'b0;
      if (Sample_Valid) begin
        r_cnt <= w_cnt_next;
        case (r_state)
          ST_INIT: begin
            r_run_max <= In_RED_Filtered;
            r_run_min <= In_RED_Filtered;
            r_state   <= ST_RISING;
          end
          ST_RISING: begin
            r_run_max <= w_max_next;
            if (w_peak_conf) begin
              r_run_min <= In_RED_Filtered;
              r_state   <= ST_FALLING;
            end
          end
          ST_FALLING: begin
            r_run_min <= w_min_next;
            if (w_trough_conf) begin
              r_trough  <= w_min_next;
              r_run_max <= In_RED_Filtered;
              r_state   <= ST_RISING;
            end
          end
          default: r_state <= ST_INIT;
        endcase

        // A peak that is too early is dropped without restarting the count,
        // so the next real peak is still timed from the last accepted one.
        if (w_peak_conf && !r_have_peak) begin
          r_have_peak <= 1'b1;
          r_cnt       <= 16'd0;
          r_timeout   <= 1'b0;
          r_peak      <= w_max_next;
        end else if (w_accept) begin
          r_period     <= w_cnt_next;
          r_peak       <= w_max_next;
          r_ac         <= w_ac_diff[20] ? 20'd0 : w_ac_diff[19:0];
          r_beat_valid <= 1'b1;
          r_cnt        <= 16'd0;
        end else if (w_cnt_next == MAX_PERIOD) begin
          r_timeout   <= 1'b1;
          r_have_peak <= 1'b0;
        end
      end
    end
  end

  assign Peak_Value   = r_peak;
  assign Trough_Value = r_trough;
  assign AC_Amplitude = r_ac;
  assign Beat_Period  = r_period;
  assign Beat_Valid   = r_beat_valid;
  assign Timeout      = r_timeout;

endmodule

// File: tb/tb_red_peak_detector.sv
// tb/tb_red_peak_detector.sv - directed self-checking bench for red_peak_detector
module tb_red_peak_detector;

  logic        clk;
  logic        rst;
  logic        sv;
  logic [19:0] din;
  logic [19:0] peak_v;
  logic [19:0] trough_v;
  logic [19:0] ac_v;
  logic [15:0] period_v;
  logic        beat_v;
  logic        to_v;

  int total = 0;
  int bad   = 0;

  int beats;
  int first_idx;
  int to_rise_idx;
  int to_fall_idx;
  logic prev_to;

  red_peak_detector dut (
    .CLK_Filter      (clk),
    .rst             (rst),
    .Sample_Valid    (sv),
    .In_RED_Filtered (din),
    .Peak_Value      (peak_v),
    .Trough_Value    (trough_v),
    .AC_Amplitude    (ac_v),
    .Beat_Period     (period_v),
    .Beat_Valid      (beat_v),
    .Timeout         (to_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] tri_val(input int n, input int base, input int step, input int half);
    int ph;
    ph = n % (2 * half);
    if (ph <= half) return 20'(base + ph * step);
    return 20'(base + (2 * half - ph) * step);
  endfunction

  task automatic trk_clear();
    beats       = 0;
    first_idx   = -1;
    to_rise_idx = -1;
    to_fall_idx = -1;
  endtask

  // One valid sample followed by one idle cycle carrying garbage data.
  task automatic send(input logic [19:0] v, input int idx);
    logic pulse;
    @(negedge clk);
    sv  = 1'b1;
    din = v;
    @(posedge clk);
    #1;
    pulse = beat_v;
    if (pulse) begin
      beats++;
      if (first_idx < 0) first_idx = idx;
    end
    if (to_v && !prev_to && to_rise_idx < 0) to_rise_idx = idx;
    if (!to_v && prev_to && to_fall_idx < 0) to_fall_idx = idx;
    prev_to = to_v;
    @(negedge clk);
    sv  = 1'b0;
    din = 20'($urandom);
    @(posedge clk);
    #1;
    if (pulse) chk("pulse_one_cycle", {31'd0, beat_v}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sv  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    prev_to = 1'b0;
    trk_clear();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_peak"},   {12'd0, peak_v},   32'd0);
    chk({tag, "_trough"}, {12'd0, trough_v}, 32'd0);
    chk({tag, "_ac"},     {12'd0, ac_v},     32'd0);
    chk({tag, "_period"}, {16'd0, period_v}, 32'd0);
    chk({tag, "_beat"},   {31'd0, beat_v},   32'd0);
    chk({tag, "_to"},     {31'd0, to_v},     32'd0);
  endtask

  initial begin
    rst = 1'b1;
    sv  = 1'b0;
    din = 20'd0;
    prev_to = 1'b0;
    trk_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    do_reset();

    // Nominal triangle 40000..60000, period 250: peaks confirm at 129,379,629,879.
    for (int n = 0; n < 1000; n++) send(tri_val(n, 40000, 160, 125), n);
    chk("tri_beats",     beats,     32'd3);
    chk("tri_first_idx", first_idx, 32'd379);
    chk("tri_period",    {16'd0, period_v}, 32'd250);
    chk("tri_peak",      {12'd0, peak_v},   32'd60000);
    chk("tri_trough",    {12'd0, trough_v}, 32'd40000);
    chk("tri_ac",        {12'd0, ac_v},     32'd20000);
    chk("tri_to",        {31'd0, to_v},     32'd0);

    // Flat input: 120 samples already counted since peak at 879, so cnt hits 1000 at c=879.
    trk_clear();
    for (int c = 0; c < 1200; c++) send(20'd1200, c);
    chk("flat_to_idx", to_rise_idx, 32'd879);
    chk("flat_to",     {31'd0, to_v},     32'd1);
    chk("flat_beats",  beats,             32'd0);
    chk("flat_peak",   {12'd0, peak_v},   32'd60000);
    chk("flat_trough", {12'd0, trough_v}, 32'd40000);
    chk("flat_ac",     {12'd0, ac_v},     32'd20000);
    chk("flat_period", {16'd0, period_v}, 32'd250);

    // Recovery: first peak (129) clears Timeout silently, next peak (379) is a beat.
    trk_clear();
    for (int n = 0; n < 500; n++) send(tri_val(n, 40000, 160, 125), n);
    chk("recov_to_fall", to_fall_idx, 32'd129);
    chk("recov_first",   first_idx,   32'd379);
    chk("recov_beats",   beats,       32'd1);
    chk("recov_trough",  {12'd0, trough_v}, 32'd40000);
    chk("recov_ac",      {12'd0, ac_v},     32'd20000);

    // Reset mid-rise, asserted together with a valid sample.
    do_reset();
    for (int n = 0; n < 300; n++) send(tri_val(n, 40000, 160, 125), n);
    chk("pre_rst_peak", {12'd0, peak_v}, 32'd60000);
    @(negedge clk);
    rst = 1'b1;
    sv  = 1'b1;
    din = tri_val(300, 40000, 160, 125);
    @(posedge clk);
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    sv  = 1'b0;
    trk_clear();
    for (int n = 301; n < 700; n++) send(tri_val(n, 40000, 160, 125), n);
    chk("midrst_first",  first_idx, 32'd629);
    chk("midrst_beats",  beats,     32'd1);
    chk("midrst_period", {16'd0, period_v}, 32'd250);

    // Sub-hysteresis swing: nothing confirmed, Timeout at the 1000th sample (index 999).
    do_reset();
    for (int n = 0; n < 1100; n++) send(tri_val(n, 39800, 4, 100), n);
    chk("small_beats",  beats,       32'd0);
    chk("small_to_idx", to_rise_idx, 32'd999);
    chk("small_peak",   {12'd0, peak_v},   32'd0);
    chk("small_period", {16'd0, period_v}, 32'd0);

    // Period 50: peak at 76 (cnt 50) rejected; count keeps running so 126 sees cnt 100.
    do_reset();
    for (int n = 0; n < 121; n++) send(tri_val(n, 40000, 800, 25), n);
    chk("short_beats",  beats,             32'd0);
    chk("short_period", {16'd0, period_v}, 32'd0);
    chk("short_ac",     {12'd0, ac_v},     32'd0);
    chk("short_peak",   {12'd0, peak_v},   32'd60000);
    for (int n = 121; n < 131; n++) send(tri_val(n, 40000, 800, 25), n);
    chk("short_late_idx",    first_idx,         32'd126);
    chk("short_late_period", {16'd0, period_v}, 32'd100);

    // Top of range: FF000..FFFFF, period 210, beats at 329 and 539.
    do_reset();
    for (int n = 0; n < 630; n++) send(tri_val(n, 32'hFF000, 39, 105), n);
    chk("hi_beats",  beats,             32'd2);
    chk("hi_peak",   {12'd0, peak_v},   32'hFFFFF);
    chk("hi_trough", {12'd0, trough_v}, 32'hFF000);
    chk("hi_ac",     {12'd0, ac_v},     32'h00FFF);
    chk("hi_period", {16'd0, period_v}, 32'd210);

    // Bottom of range: 0..FFF.
    do_reset();
    for (int n = 0; n < 630; n++) send(tri_val(n, 0, 39, 105), n);
    chk("lo_beats",  beats,             32'd2);
    chk("lo_peak",   {12'd0, peak_v},   32'h00FFF);
    chk("lo_trough", {12'd0, trough_v}, 32'd0);
    chk("lo_ac",     {12'd0, ac_v},     32'h00FFF);
    chk("lo_period", {16'd0, period_v}, 32'd210);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
